// File: rtl/cnn_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module : cnn_div_pkg
//  Shared widths, saturation bounds and FSM encoding for the CNN divider.
//  Rev    : 1.0
// ============================================================================
package cnn_div_pkg;

    localparam int C_DIVIDEND_W = 24;
    localparam int C_DIVISOR_W  = 10;
    localparam int C_QUOT_W     = 14;
    localparam int C_ITER_CNT_W = 5;

    localparam int C_QMAX = 8191;
    localparam int C_QMIN = -8192;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cnn_sdiv_step.sv
`default_nettype none
// ============================================================================
//  Module : cnn_sdiv_step
//  One combinational radix-2 restoring step on unsigned magnitudes.
//  Rev    : 1.0
// ============================================================================
module cnn_sdiv_step
    import cnn_div_pkg::*;
#(
    parameter int DIVISOR_W = C_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   i_partial_in,
    input  logic                 i_bit_in,
    input  logic [DIVISOR_W-1:0] i_divisor_mag,
    output logic [DIVISOR_W:0]   o_partial_out,
    output logic                 o_q_bit
);

    logic [DIVISOR_W+1:0] w_trial;
    logic [DIVISOR_W:0]   w_diff;

    assign w_trial = {i_partial_in, i_bit_in};
    // Subtraction is only taken when trial >= divisor, so the top bit is never needed.
    assign w_diff  = w_trial[DIVISOR_W:0] - {1'b0, i_divisor_mag};

    always_comb begin
        o_q_bit       = 1'b0;
        o_partial_out = w_trial[DIVISOR_W:0];
        if (w_trial >= {2'b00, i_divisor_mag}) begin
            o_q_bit       = 1'b1;
            o_partial_out = w_diff;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cnn_sdiv_24s_10s_seq.sv
`default_nettype none
// ============================================================================
//  Module : cnn_sdiv_24s_10s_seq
//  Sequential signed divider 24s / 10s -> 14s quotient (saturated) + 10s rem.
//  Rev    : 1.0
// ============================================================================
module cnn_sdiv_24s_10s_seq
    import cnn_div_pkg::*;
#(
    parameter int DIVIDEND_W = C_DIVIDEND_W,
    parameter int DIVISOR_W  = C_DIVISOR_W,
    parameter int QUOT_W     = C_QUOT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  ap_idle,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic [QUOT_W-1:0]     quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int ITER_CNT_W = C_ITER_CNT_W;
    localparam logic [ITER_CNT_W-1:0] C_LAST_ITER = ITER_CNT_W'(DIVIDEND_W - 1);
    localparam logic [DIVIDEND_W-1:0] C_POS_LIM   = DIVIDEND_W'((1 << (QUOT_W - 1)) - 1);
    localparam logic [DIVIDEND_W-1:0] C_NEG_LIM   = DIVIDEND_W'(1 << (QUOT_W - 1));
    localparam logic [QUOT_W-1:0]     C_QMAX_V    = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0]     C_QMIN_V    = {1'b1, {(QUOT_W-1){1'b0}}};

    state_t r_state, w_state_nxt;

    logic [ITER_CNT_W-1:0] r_cnt;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_dsr_mag;
    logic [DIVISOR_W:0]    r_part;
    logic                  r_dvd_neg;
    logic                  r_dsr_neg;
    logic                  r_dz;

    logic [QUOT_W-1:0]     r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_by_zero;
    logic                  r_overflow;

    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dsr_mag;
    logic [DIVISOR_W:0]    w_part_nxt;
    logic                  w_q_bit;
    logic                  w_q_neg;
    logic [QUOT_W-1:0]     w_qlow;
    logic [QUOT_W-1:0]     w_quo_fix;
    logic [DIVISOR_W-1:0]  w_rem_fix;
    logic                  w_ovf_fix;

    // Two's-complement negation maps the most negative input onto its exact magnitude.
    assign w_dvd_mag = dividend[DIVIDEND_W-1] ? -dividend : dividend;
    assign w_dsr_mag = divisor[DIVISOR_W-1]   ? -divisor  : divisor;

    cnn_sdiv_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .i_partial_in  (r_part),
        .i_bit_in      (r_dvd[DIVIDEND_W-1]),
        .i_divisor_mag (r_dsr_mag),
        .o_partial_out (w_part_nxt),
        .o_q_bit       (w_q_bit)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        ap_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) w_state_nxt = CALC;
            end
            CALC: if (r_cnt == C_LAST_ITER) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: begin
                ap_done     = 1'b1;
                ap_ready    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sign fix-up and saturation of the magnitude results.
    assign w_q_neg = r_dvd_neg ^ r_dsr_neg;
    assign w_qlow  = r_quo[QUOT_W-1:0];

    always_comb begin
        w_quo_fix = w_qlow;
        w_ovf_fix = 1'b0;
        w_rem_fix = r_dvd_neg ? -r_part[DIVISOR_W-1:0] : r_part[DIVISOR_W-1:0];
        if (r_dz) begin
            w_quo_fix = r_dvd_neg ? C_QMIN_V : C_QMAX_V;
            w_rem_fix = '0;
        end else if (w_q_neg) begin
            if (r_quo > C_NEG_LIM) begin
                w_quo_fix = C_QMIN_V;
                w_ovf_fix = 1'b1;
            end else begin
                w_quo_fix = -w_qlow;
            end
        end else if (r_quo > C_POS_LIM) begin
            w_quo_fix = C_QMAX_V;
            w_ovf_fix = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_cnt         <= '0;
            r_dvd         <= '0;
            r_quo         <= '0;
            r_dsr_mag     <= '0;
            r_part        <= '0;
            r_dvd_neg     <= 1'b0;
            r_dsr_neg     <= 1'b0;
            r_dz          <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (ap_start) begin
                    r_dvd     <= w_dvd_mag;
                    r_dsr_mag <= w_dsr_mag;
                    r_dvd_neg <= dividend[DIVIDEND_W-1];
                    r_dsr_neg <= divisor[DIVISOR_W-1];
                    r_dz      <= (divisor == '0);
                    r_cnt     <= '0;
                    r_part    <= '0;
                    r_quo     <= '0;
                end
                CALC: begin
                    r_part <= w_part_nxt;
                    r_quo  <= {r_quo[DIVIDEND_W-2:0], w_q_bit};
                    r_dvd  <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
                    r_cnt  <= (r_cnt == C_LAST_ITER) ? '0 : r_cnt + 1'b1;
                end
                FIX: begin
                    r_quotient    <= w_quo_fix;
                    r_remainder   <= w_rem_fix;
                    r_div_by_zero <= r_dz;
                    r_overflow    <= w_ovf_fix;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_cnn_sdiv_24s_10s_seq.sv
`default_nettype none
// ============================================================================
//  Module : tb_cnn_sdiv_24s_10s_seq
//  Directed + random bench for the sequential signed divider.
//  Rev    : 1.0
// ============================================================================
module tb_cnn_sdiv_24s_10s_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic [23:0] dividend;
    logic [9:0]  divisor;
    logic        ap_idle;
    logic        ap_done;
    logic        ap_ready;
    logic [13:0] quotient;
    logic [9:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_cmp = 0;
    int n_mis = 0;

    cnn_sdiv_24s_10s_seq dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .ap_ready    (ap_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: C-style truncating division, then clamp to the 14-bit range.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int dz, output int ov);
        dz = 0;
        ov = 0;
        if (b == 0) begin
            q  = (a >= 0) ? 8191 : -8192;
            r  = 0;
            dz = 1;
        end else begin
            q = a / b;
            r = a % b;
            if (q > 8191) begin
                q  = 8191;
                ov = 1;
            end else if (q < -8192) begin
                q  = -8192;
                ov = 1;
            end
        end
    endfunction

    task automatic chk_result(input string tag, input int a, input int b);
        int q, r, dz, ov;
        ref_div(a, b, q, r, dz, ov);
        chk({tag, "_ready"}, int'(ap_ready), 1);
        chk({tag, "_quot"},  int'($signed(quotient)), q);
        chk({tag, "_rem"},   int'($signed(remainder)), r);
        chk({tag, "_dz"},    int'(div_by_zero), dz);
        chk({tag, "_ovf"},   int'(overflow), ov);
    endtask

    // Caller is positioned just after a negedge with the DUT idle.
    task automatic run_op(input int a, input int b, input string tag);
        int  cyc;
        bit  seen;
        bit  idle_bad;
        ap_start = 1'b1;
        dividend = 24'(a);
        divisor  = 10'(b);
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        dividend = 24'($urandom);
        divisor  = 10'($urandom);
        cyc      = 1;
        seen     = 1'b0;
        idle_bad = 1'b0;
        while (cyc <= 40) begin
            if (ap_done) begin
                seen = 1'b1;
                break;
            end
            if (ap_idle) idle_bad = 1'b1;
            @(negedge ap_clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
        chk({tag, "_latency"}, cyc, 26);
        chk({tag, "_idle_low"}, int'(idle_bad), 0);
        chk_result(tag, a, b);
        @(negedge ap_clk);
        chk({tag, "_done_pulse"}, int'(ap_done), 0);
        chk({tag, "_idle_back"}, int'(ap_idle), 1);
    endtask

    initial begin
        int a, b, mode, spurious, cyc, gap;
        logic signed [23:0] ra;
        logic signed [9:0]  rb;

        ap_rst   = 1'b1;
        ap_start = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge ap_clk);
        chk("rst_idle", int'(ap_idle), 1);
        chk("rst_done", int'(ap_done), 0);
        chk("rst_ready", int'(ap_ready), 0);
        chk("rst_quot", int'(quotient), 0);
        chk("rst_rem", int'(remainder), 0);
        chk("rst_flags", int'({div_by_zero, overflow}), 0);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        run_op(1000, 7, "pp");
        run_op(-1000, 7, "np");
        run_op(1000, -7, "pn");
        run_op(8388607, 1, "sat_pos");
        run_op(-8388608, -512, "sat_minmin");
        run_op(-8192, 1, "qmin_exact");
        run_op(8191, 1, "qmax_exact");
        run_op(5, 0, "dz_pos");
        run_op(-5, 0, "dz_neg");
        run_op(100, 10, "dz_clear");
        run_op(-1000, -7, "nn");

        // Abort mid-CALC with an asynchronous reset.
        ap_start = 1'b1;
        dividend = 24'(100000);
        divisor  = 10'(3);
        @(posedge ap_clk);
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (10) @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        chk("abort_quot", int'(quotient), 0);
        chk("abort_rem", int'(remainder), 0);
        chk("abort_flags", int'({div_by_zero, overflow}), 0);
        chk("abort_idle", int'(ap_idle), 1);
        chk("abort_done", int'(ap_done), 0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst   = 1'b0;
        spurious = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge ap_clk);
            if (ap_done) spurious++;
        end
        chk("abort_no_done", spurious, 0);
        run_op(50, 3, "post_abort");

        // Back-to-back operations with ap_start held and inputs disturbed mid-CALC.
        ap_start = 1'b1;
        dividend = 24'(123456);
        divisor  = 10'(-77);
        @(posedge ap_clk);
        @(negedge ap_clk);
        dividend = 24'($urandom);
        divisor  = 10'($urandom);
        repeat (5) @(negedge ap_clk);
        dividend = 24'(-654321);
        divisor  = 10'(99);
        cyc = 1;
        while (cyc <= 40 && !ap_done) begin
            @(negedge ap_clk);
            cyc++;
        end
        chk("hold1_done_seen", int'(ap_done), 1);
        chk_result("hold1", 123456, -77);
        gap = 0;
        @(negedge ap_clk);
        gap++;
        @(negedge ap_clk);
        gap++;
        ap_start = 1'b0;
        while (gap <= 40 && !ap_done) begin
            @(negedge ap_clk);
            gap++;
        end
        chk("hold_gap", gap, 27);
        chk_result("hold2", -654321, 99);
        @(negedge ap_clk);

        for (int i = 0; i < 40; i++) begin
            mode = int'($urandom_range(0, 3));
            ra   = 24'($urandom);
            rb   = 10'($urandom);
            a    = int'(ra);
            b    = int'(rb);
            case (mode)
                1: a = int'($urandom_range(0, 2000000)) - 1000000;
                2: a = int'($urandom_range(0, 40000)) - 20000;
                3: begin
                    a = int'($urandom_range(0, 40000)) - 20000;
                    b = int'($urandom_range(0, 6)) - 3;
                end
                default: ;
            endcase
            if (i % 10 == 7) b = 0;
            run_op(a, b, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cnn_sdiv_24s_10s_seq.md
Name: cnn_sdiv_24s_10s_seq

Overview:
- Sequential signed fixed-point divider for the CNN datapath: 24-bit signed dividend / 10-bit signed divisor -> 14-bit signed quotient plus 10-bit signed remainder.
- Inverse of the 14s x 10s -> 24s product path. Used to rescale conv2 accumulations back to the 14-bit activation format, e.g. for average/normalisation.
- Radix-2 restoring iteration on magnitudes, then sign fix-up and saturation.
- Block-level start/done handshake, same control style as the surrounding datapath.

Parameters:
- DIVIDEND_W, 24, dividend width and iteration count.
- DIVISOR_W, 10, divisor and remainder width.
- QUOT_W, 14, quotient output width; saturation bound.
- Only the defaults are verified.

Ports:
- ap_clk  in  1  clock; all state on rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- ap_start  in  1  request; sampled only in IDLE.
- dividend  in  24  signed; captured when start is accepted.
- divisor  in  10  signed; captured when start is accepted.
- ap_idle  out  1  high in IDLE.
- ap_done  out  1  one-cycle pulse; results valid from this cycle.
- ap_ready  out  1  one-cycle pulse, coincident with ap_done.
- quotient  out  14  signed, truncated toward zero, saturated.
- remainder  out  10  signed; sign follows dividend (C semantics).
- div_by_zero  out  1  set for the result of a zero-divisor operation.
- overflow  out  1  set when the true quotient falls outside [-8192, 8191].

Behaviour:
- Reset, asynchronous: state=IDLE; ap_idle=1; ap_done=ap_ready=0; quotient, remainder, div_by_zero, overflow = 0. Internal registers are cleared.
- Reset mid-operation aborts the operation. No ap_done is produced for it.
- States:
  - IDLE -> CALC when ap_start=1. In that cycle: capture |dividend| (24-bit unsigned, -2^23 -> 2^23), |divisor| (10-bit unsigned, -512 -> 512), both signs, and the zero-divisor flag. Clear the iteration counter and partial remainder.
  - CALC, exactly 24 cycles, MSB first. Each step: partial = {partial, next dividend bit}; if partial >= |divisor|, subtract it and shift in quotient bit 1, else shift in 0. The counter wraps 23 -> FIX.
  - FIX, 1 cycle: apply signs. Quotient sign = XOR of input signs; remainder sign = dividend sign. Saturate and register the outputs.
  - DONE, 1 cycle: ap_done=ap_ready=1 -> IDLE.
- Latency: start sampled in cycle 0 -> ap_done high in cycle 26. Throughput is one operation per 27 cycles with ap_start held high.
- ap_start is ignored outside IDLE. Inputs may change freely after the accept cycle.
- Saturation: signed quotient > 8191 -> 8191, < -8192 -> -8192, overflow=1. The remainder is always the true remainder, since |r| <= 511 fits in 10 bits.
- Divisor 0: latency unchanged. Quotient = 8191 if dividend >= 0, else -8192; remainder=0; div_by_zero=1; overflow=0.
- Outputs hold their last values until the next FIX cycle. Flags are rewritten on every operation.
- Partial remainder register is DIVISOR_W+1 bits to hold the pre-subtract value. No arithmetic wraps internally.

Decomposition:
- Package cnn_div_pkg:
  - width constants DIVIDEND_W, DIVISOR_W, QUOT_W;
  - QMAX=8191, QMIN=-8192;
  - state enum {IDLE, CALC, FIX, DONE};
  - ITER_CNT_W=5.
- Sub-module cnn_sdiv_step: combinational single restoring step, (partial_in, bit_in, divisor_mag) -> (partial_out, q_bit). Instantiated once. The top owns the FSM, counter, sign and saturation logic.

Test Plan:
- 1000 / 7 -> quotient=142, remainder=6, flags 0, ap_done exactly 26 cycles after the accepted start, ap_idle low throughout.
- -1000 / 7 -> -142, -6; 1000 / -7 -> -142, 6; -1000 / -7 -> 142, -6.
- Saturation: 8388607 / 1 -> 8191, overflow=1. -8388608 / -512 -> 8191, r=0, overflow=1. -8192 / 1 -> -8192, overflow=0.
- Zero divisor: 5 / 0 -> 8191, r=0, div_by_zero=1. -5 / 0 -> -8192, div_by_zero=1. The next op, 100 / 10 -> 10, clears the flag.
- Reset: assert ap_rst 10 cycles into CALC -> all outputs 0 immediately, ap_idle=1, no ap_done. The next 50 / 3 -> 16, r=2.
- ap_start held high across two operations, inputs changed mid-CALC -> first result unaffected by the changes. Second start accepted in the IDLE cycle after DONE, so ap_done pulses are 27 cycles apart.
